bin_to_bcd: RTL
===============

# bin_to_bcd

Sequential double-dabble converter that turns a 32-bit unsigned binary value into eight packed BCD digits. It sits directly upstream of the board's seven-segment scanner: its `bcd` output drives the scanner's 32-bit `number` input, so register contents from the CPU core show as decimal instead of hex. It runs one shift/adjust iteration per clock under a start/busy/done handshake, so the operand can come from any slow or registered source.

## Interface
Parameters:
- none; width is fixed at 32-bit binary in, 8 BCD digits out, with a 10-digit internal scratch.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  conversion request; sampled only in IDLE.
- `bin`  in  32  unsigned operand; sampled on the accepting edge only.
- `busy`  out  1  high while a conversion is in progress, SHIFT and DONE states included.
- `done`  out  1  one-cycle pulse; marks the cycle in which `bcd` and `overflow` first show the new result.
- `bcd`  out  32  packed BCD result; nibble k is decimal digit k (10^k), least significant digit in bits [3:0].
- `overflow`  out  1  high when `bin` > 99,999,999, i.e. digit 8 or digit 9 of the result is nonzero.

## Operation
- Internal state:
  - FSM with states IDLE, SHIFT, DONE.
  - 32-bit operand shift register.
  - 40-bit BCD scratch (10 digits).
  - 5-bit iteration counter.
- IDLE:
  - If `start` = 1, latch `bin` into the operand register, clear the scratch and counter, and go to SHIFT.
  - If `start` = 0, stay in IDLE.
- SHIFT, one iteration per cycle:
  - Every scratch nibble ≥ 5 gets +3 (4-bit add, no carry between nibbles).
  - Shift the adjusted scratch left by 1, with operand bit 31 entering scratch bit 0.
  - Shift the operand left by 1.
  - Increment the counter.
  - After the 32nd iteration (counter was 31), go to DONE.
- DONE:
  - Update `bcd` and `overflow` from the scratch.
  - Pulse `done` for one cycle.
  - Return to IDLE.
- `bcd` and `overflow` hold their last values until the next DONE. They never show intermediate scratch values.
- `start` in SHIFT or DONE is ignored; requests are not queued.
- `bin` may change freely after the accepting edge.
- Reset, including mid-conversion: FSM → IDLE and scratch, operand and counter → 0. The in-flight conversion is discarded and no `done` pulse is produced.

## Timing
- Reset values: `busy` = 0, `done` = 0, `bcd` = 32'h0, `overflow` = 0.
- Take edge E0 as the edge where `start` is sampled high in IDLE:
  - `busy` is high in the cycles after edges E0 through E32.
  - Iterations occur on edges E1–E32.
  - On edge E33, `bcd`, `overflow` and `done` = 1 update together and `busy` falls.
- Latency from the start edge to the `done` edge is 33 clocks.
- The earliest next accepted `start` is on edge E34, the edge that ends the `done` cycle, so the start-to-start period is 34 clocks.
- Holding `start` high continuously gives back-to-back conversions every 34 clocks.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `BCD_OVERFLOW_SAT_EN` defined:
  - When `overflow` = 1, `bcd` is forced to 32'h99999999 at DONE, so the display saturates.
- `BCD_OVERFLOW_SAT_EN` undefined:
  - `bcd` is always scratch[31:0], i.e. the value modulo 10^8.
  - `overflow` still reports the condition.
- Latency and handshake are identical in both builds.

## Test plan
- Reset, then hold `rst` = 0 for 3 clocks → all outputs 0; `busy` stays 0 with `start` = 1 held.
- `bin` = 32'h00BC614E (12,345,678), pulse `start` → `done` on the 33rd edge after the start edge; `bcd` = 32'h12345678, `overflow` = 0. Also `bin` = 0 → `bcd` = 32'h00000000.
- Boundary operands:
  - `bin` = 32'h05F5E0FF (99,999,999) → `bcd` = 32'h99999999, `overflow` = 0.
  - `bin` = 32'h05F5E100 (100,000,000) → `overflow` = 1; `bcd` = 32'h99999999 with the macro, 32'h00000000 without.
- `bin` = 32'hFFFFFFFF (4,294,967,295) → `overflow` = 1; `bcd` = 32'h94967295 without the macro, 32'h99999999 with it.
- Pulse `start` with `bin` = 5, then on edge E10 pulse `start` again with `bin` = 7 → single result `bcd` = 32'h00000005 at E33; then `start` held high → next accepted at E34, `done` at E67.
- Start a conversion of 12,345,678 and assert `rst` on edge E15 → outputs immediately 0; no `done` pulse; a fresh conversion after reset gives the correct result.

Source files
------------

// File: rtl/bin_to_bcd.sv
// bin_to_bcd: sequential double-dabble, 32-bit binary to 8 packed BCD digits.
// Optional macro BCD_OVERFLOW_SAT_EN: saturate bcd to 99999999 on overflow.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-low reset
//   start    in   conversion request, sampled in IDLE only
//   bin      in   32-bit unsigned operand, sampled on the accepting edge
//   busy     out  conversion in progress (SHIFT and DONE)
//   done     out  one-cycle pulse when bcd/overflow show a new result
//   bcd      out  packed BCD, digit k in bits [4k+3:4k]
//   overflow out  operand exceeded 99,999,999
module bin_to_bcd (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] bin,
    output logic        busy,
    output logic        done,
    output logic [31:0] bcd,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] opnd;
    logic [39:0] scr;
    logic [4:0]  cnt;
    logic [39:0] adj;
    logic        ovf_w;

    // Each digit >= 5 gets +3 so the following shift carries into
    // the next digit; no carry propagates between nibbles here.
    always_comb begin
        adj = scr;
        for (int k = 0; k < 10; k++) begin
            if (scr[4*k +: 4] >= 4'd5)
                adj[4*k +: 4] = scr[4*k +: 4] + 4'd3;
        end
    end

    // Digits 8 and 9 are only nonzero when the operand is >= 10^8.
    assign ovf_w = |scr[39:32];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            opnd     <= '0;
            scr      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        opnd  <= bin;
                        scr   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    scr  <= {adj[38:0], opnd[31]};
                    opnd <= {opnd[30:0], 1'b0};
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'd31)
                        state <= DONE;
                end
                DONE: begin
`ifdef BCD_OVERFLOW_SAT_EN
                    bcd <= ovf_w ? 32'h9999_9999 : scr[31:0];
`else
                    bcd <= scr[31:0];
`endif
                    overflow <= ovf_w;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
